mem_access_unit: RTL

Load/store sequencer directly upstream of the word-addressed data memory in the non-pipelined MIPS datapath. Accepts one byte-addressed load or store request from the control/ALU side and converts it to word-index memory accesses. Sub-word stores use read-modify-write. Returns sign- or zero-extended load data with a one-cycle response pulse, and flags faulting requests without touching memory.

---
 rtl/mem_access_unit.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store sequencer in front of the
// word-addressed data memory. Sub-word stores are read-modify-write;
// faulting requests are answered without any memory access.
// Optional feature macro: MEM_ACCESS_STATS_EN (load/store/fault counters).
module mem_access_unit #(
    parameter int unsigned MEM_DEPTH = 512,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_fault,
    output logic [1:0]       resp_cause,
`ifdef MEM_ACCESS_STATS_EN
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] fault_count,
`endif
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    output logic             mem_write_enable,
    output logic             mem_read_enable,
    input  logic [31:0]      mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        FAULT
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;
    localparam logic [1:0] CAUSE_SIZE  = 2'b11;

    // Counters need at least one bit.
    if (CNT_W == 0) begin : g_cnt_w_check
        $error("mem_access_unit: CNT_W must be at least 1");
    end

    state_t      state_q, state_d;
    logic        accept;
    logic [1:0]  chk_cause;
    logic [31:0] word_idx;

    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        uns_q;
    logic [15:0] wdata_q;
    logic [1:0]  cause_q;
    logic [31:0] rdata_q;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept   = req_valid && (state_q == IDLE);
    assign word_idx = {2'b00, req_addr[31:2]};

    // Classify the incoming request; size beats alignment beats range.
    always_comb begin
        chk_cause = CAUSE_NONE;
        if (req_size == SZ_RSVD) begin
            chk_cause = CAUSE_SIZE;
        end else if ((req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00)) begin
            chk_cause = CAUSE_ALIGN;
        end else if (word_idx >= MEM_DEPTH) begin
            chk_cause = CAUSE_RANGE;
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        rd_byte  = '0;
        rd_half  = '0;
        load_ext = mem_read_data;
        merged   = mem_read_data;
        case (addr_lo_q)
            2'd0:    rd_byte = mem_read_data[7:0];
            2'd1:    rd_byte = mem_read_data[15:8];
            2'd2:    rd_byte = mem_read_data[23:16];
            default: rd_byte = mem_read_data[31:24];
        endcase
        rd_half = addr_lo_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            SZ_BYTE: begin
                load_ext = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
                case (addr_lo_q)
                    2'd0:    merged[7:0]   = wdata_q[7:0];
                    2'd1:    merged[15:8]  = wdata_q[7:0];
                    2'd2:    merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                load_ext = {{16{rd_half[15] & ~uns_q}}, rd_half};
                if (addr_lo_q[1]) begin
                    merged[31:16] = wdata_q;
                end else begin
                    merged[15:0] = wdata_q;
                end
            end
            default: begin
                load_ext = mem_read_data;
                merged   = mem_read_data;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        resp_valid       = 1'b0;
        resp_fault       = 1'b0;
        resp_cause       = CAUSE_NONE;
        resp_rdata       = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (chk_cause != CAUSE_NONE) begin
                        state_d = FAULT;
                    end else if (req_write && req_size == SZ_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mem_read_enable = 1'b1;
                state_d         = write_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_write_enable = 1'b1;
                state_d          = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = write_q ? '0 : rdata_q;
                state_d    = IDLE;
            end
            FAULT: begin
                resp_valid = 1'b1;
                resp_fault = 1'b1;
                resp_cause = cause_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, memory address/data registers and load result.
    // Address and write data only move for non-faulting requests, so a
    // rejected request leaves the memory-side outputs untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_q      <= '0;
            size_q         <= '0;
            write_q        <= 1'b0;
            uns_q          <= 1'b0;
            wdata_q        <= '0;
            cause_q        <= CAUSE_NONE;
            rdata_q        <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            if (accept) begin
                addr_lo_q <= req_addr[1:0];
                size_q    <= req_size;
                write_q   <= req_write;
                uns_q     <= req_unsigned;
                wdata_q   <= req_wdata[15:0];
                cause_q   <= chk_cause;
                if (chk_cause == CAUSE_NONE) begin
                    mem_address <= word_idx;
                    if (req_write && req_size == SZ_WORD) begin
                        mem_write_data <= req_wdata;
                    end
                end
            end
            if (state_q == READ) begin
                if (write_q) begin
                    mem_write_data <= merged;
                    rdata_q        <= '0;
                end else begin
                    rdata_q <= load_ext;
                end
            end
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    // Saturating completion counters, bumped on the response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count  <= '0;
            store_count <= '0;
            fault_count <= '0;
        end else begin
            if (state_q == RESP && !write_q && load_count != '1) begin
                load_count <= load_count + 1'b1;
            end
            if (state_q == RESP && write_q && store_count != '1) begin
                store_count <= store_count + 1'b1;
            end
            if (state_q == FAULT && fault_count != '1) begin
                fault_count <= fault_count + 1'b1;
            end
        end
    end
`endif

endmodule
